// File: rtl/reg_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : reg_trace_monitor
// Purpose  : Run monitor for the RV32I core. Snoops the register-file write
//            port and the PC, time-stamps writes to a watched register set
//            into a show-ahead trace FIFO, and flags program completion on
//            a PC stall (HALT) or an exhausted cycle budget (TMO).
// Ports    : clk, rst (async, active-low)
//            start                         - arm / re-arm a run (1-cycle pulse)
//            rf_we, rf_waddr, rf_wdata     - snooped register-file write port
//            pc                            - current program counter
//            trc_valid/ready, trc_cycle/addr/data - trace FIFO read-out
//            cycle_cnt, drop_cnt, state, done     - run status
// Revision : 1.0 - initial release
// ============================================================================
module reg_trace_monitor #(
  parameter int          XLEN           = 32,
  parameter int          DEPTH          = 16,
  parameter int          CW             = 16,
  parameter logic [31:0] WATCH_MASK     = 32'hFFFF_FFFE,
  parameter int          HALT_CYCLES    = 8,
  parameter int          TIMEOUT_CYCLES = 75
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            rf_we,
  input  logic [4:0]      rf_waddr,
  input  logic [XLEN-1:0] rf_wdata,
  input  logic [XLEN-1:0] pc,
  output logic            trc_valid,
  input  logic            trc_ready,
  output logic [CW-1:0]   trc_cycle,
  output logic [4:0]      trc_addr,
  output logic [XLEN-1:0] trc_data,
  output logic [CW-1:0]   cycle_cnt,
  output logic [7:0]      drop_cnt,
  output logic [1:0]      state,
  output logic            done
);

  localparam int AW = $clog2(DEPTH);
  // Stall counter only needs to reach HALT_CYCLES-1.
  localparam int SW = $clog2(HALT_CYCLES);
  localparam int EW = CW + 5 + XLEN;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_TMO  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cycle_q, cycle_d;
  logic [7:0]      drop_q, drop_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [XLEN-1:0] pc_prev_q, pc_prev_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [EW-1:0]   mem_q [DEPTH];

  logic in_run, cap_hit, push_req, push_ok, pop, full;
  logic pc_same, halt_hit, tmo_hit;

  assign in_run   = (state_q == S_RUN);
  assign cap_hit  = rf_we && (rf_waddr != 5'd0) && WATCH_MASK[rf_waddr];
  // A start in the same cycle restarts the run, so its capture is discarded.
  assign push_req = in_run && !start && cap_hit;
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign pop      = (count_q != '0) && trc_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok  = push_req && (!full || pop);
  assign pc_same  = (pc == pc_prev_q);
  assign halt_hit = pc_same && (stall_q == SW'(HALT_CYCLES - 1));
  assign tmo_hit  = (cycle_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    drop_d    = drop_q;
    stall_d   = stall_q;
    pc_prev_d = pc;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (start) begin
      state_d  = S_RUN;
      cycle_d  = '0;
      drop_d   = '0;
      stall_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (in_run) begin
        // HALT takes priority over timeout; the counter freezes on the
        // edge that leaves RUN so it reports the last RUN cycle index.
        if (halt_hit)
          state_d = S_HALT;
        else if (tmo_hit)
          state_d = S_TMO;
        else
          cycle_d = cycle_q + CW'(1);

        if (!pc_same)
          stall_d = '0;
        else if (stall_q != SW'(HALT_CYCLES - 1))
          stall_d = stall_q + SW'(1);

        if (push_req && !push_ok && (drop_q != 8'hFF))
          drop_d = drop_q + 8'd1;
      end

      if (push_ok)
        wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)
        rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cycle_q   <= '0;
      drop_q    <= '0;
      stall_q   <= '0;
      pc_prev_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      drop_q    <= drop_d;
      stall_q   <= stall_d;
      pc_prev_q <= pc_prev_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage carries no reset; unused slots are masked at the read-out.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= {cycle_q, rf_waddr, rf_wdata};
  end

  assign trc_valid = (count_q != '0);
  assign {trc_cycle, trc_addr, trc_data} = trc_valid ? mem_q[rd_ptr_q] : '0;

  assign cycle_cnt = cycle_q;
  assign drop_cnt  = drop_q;
  assign state     = state_q;
  assign done      = (state_q == S_HALT) || (state_q == S_TMO);

endmodule
`default_nettype wire

// File: tb/tb_reg_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_trace_monitor
// Purpose  : Self-checking bench for reg_trace_monitor. Expected trace
//            entries are queued when a watched write is driven and compared
//            when the DUT hands an entry out. A second instance with a narrow
//            watch mask checks register filtering.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_trace_monitor;

  localparam int XLEN  = 32;
  localparam int CW    = 16;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            rf_we = 1'b0;
  logic [4:0]      rf_waddr = '0;
  logic [XLEN-1:0] rf_wdata = '0;
  logic [XLEN-1:0] pc = '0;
  logic            trc_ready = 1'b0;

  logic            trc_valid, done;
  logic [CW-1:0]   trc_cycle, cycle_cnt;
  logic [4:0]      trc_addr;
  logic [XLEN-1:0] trc_data;
  logic [7:0]      drop_cnt;
  logic [1:0]      state;

  logic            m_valid, m_done;
  logic [CW-1:0]   m_cycle, m_cycle_cnt;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;
  logic [7:0]      m_drop;
  logic [1:0]      m_state;

  reg_trace_monitor u_dut (
    .clk(clk), .rst(rst), .start(start),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc(pc),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_cycle(trc_cycle),
    .trc_addr(trc_addr), .trc_data(trc_data), .cycle_cnt(cycle_cnt),
    .drop_cnt(drop_cnt), .state(state), .done(done)
  );

  reg_trace_monitor #(.WATCH_MASK(32'h0000_0400)) u_msk (
    .clk(clk), .rst(rst), .start(start),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc(pc),
    .trc_valid(m_valid), .trc_ready(trc_ready), .trc_cycle(m_cycle),
    .trc_addr(m_addr), .trc_data(m_data), .cycle_cnt(m_cycle_cnt),
    .drop_cnt(m_drop), .state(m_state), .done(m_done)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          run_cyc = 0;
  logic        pc_hold = 1'b0;
  logic [63:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    run_cyc++;
    if (!pc_hold) pc = pc + 32'd4;
  endtask

  task automatic run_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    sb_q.delete();
    run_cyc = 0;
  endtask

  // Drive one register write during RUN; queue the entry the default-mask
  // instance must produce, unless it is filtered or lost to a full FIFO.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] mask;
    logic [CW-1:0] ts;
    mask = 32'hFFFF_FFFE;
    ts = run_cyc[CW-1:0];
    rf_we = 1'b1;
    rf_waddr = a;
    rf_wdata = d;
    if (a != 5'd0 && mask[a] && (sb_q.size() < DEPTH || trc_ready))
      sb_q.push_back({11'd0, ts, a, d});
    tick();
    rf_we = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && trc_valid && trc_ready) begin
      if (sb_q.size() == 0)
        chk("sb_extra", {11'd0, trc_cycle, trc_addr, trc_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      else
        chk("sb_entry", {11'd0, trc_cycle, trc_addr, trc_data}, sb_q.pop_front());
    end
  end

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_state", state, 2'd0);
    chk("rst_valid", trc_valid, 1'b0);
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_done", done, 1'b0);
    chk("rst_data", trc_data, 0);
    rst = 1'b1;
    tick();
    chk("idle_no_run", state, 2'd0);

    // Single capture, one-cycle latency
    trc_ready = 1'b1;
    pc = 32'h100;
    run_start();
    chk("t1_state", state, 2'd1);
    chk("t1_cycle0", cycle_cnt, 0);
    repeat (3) tick();
    wr(5'd10, 32'd5);
    chk("t1_valid", trc_valid, 1'b1);
    chk("t1_ts", trc_cycle, 3);
    chk("t1_addr", trc_addr, 10);
    chk("t1_data", trc_data, 5);
    tick();
    chk("t1_empty", trc_valid, 1'b0);

    // Register filtering
    run_start();
    wr(5'd0, 32'h11);
    chk("t2_x0_none", trc_valid, 1'b0);
    wr(5'd1, 32'h22);
    chk("t2_msk_x1", m_valid, 1'b0);
    chk("t2_def_x1", trc_addr, 1);
    chk("t2_msk_drop", m_drop, 0);
    wr(5'd10, 32'h33);
    chk("t2_msk_x10v", m_valid, 1'b1);
    chk("t2_msk_x10a", m_addr, 10);
    chk("t2_msk_x10d", m_data, 32'h33);
    tick();
    chk("t2_def_drop", drop_cnt, 0);

    // Overflow, drops, push-at-full with pop
    run_start();
    trc_ready = 1'b0;
    for (int i = 0; i < 20; i++) wr(5'd15, 32'h100 + i);
    chk("t3_drop", drop_cnt, 4);
    chk("t3_head_ts", trc_cycle, 0);
    tick();
    chk("t3_hold_ts", trc_cycle, 0);
    chk("t3_hold_dat", trc_data, 32'h100);
    trc_ready = 1'b1;
    wr(5'd15, 32'hAA);
    repeat (16) tick();
    chk("t3_drained", sb_q.size(), 0);
    chk("t3_empty", trc_valid, 1'b0);
    chk("t3_drop2", drop_cnt, 4);

    // Halt detection
    pc_hold = 1'b1;
    pc = 32'h18;
    run_start();
    for (int k = 1; k <= 10; k++) begin
      pc = 32'h18 + 32'd4 * k;
      tick();
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t4_still_run", state, 2'd1);
    end
    tick();
    chk("t4_halt", state, 2'd2);
    chk("t4_done", done, 1'b1);
    chk("t4_cycle", cycle_cnt, 17);
    repeat (3) tick();
    chk("t4_frozen", cycle_cnt, 17);
    rf_we = 1'b1;
    rf_waddr = 5'd5;
    rf_wdata = 32'h55;
    tick();
    rf_we = 1'b0;
    chk("t4_no_cap", trc_valid, 1'b0);

    // Timeout, then halt and timeout on the same edge
    pc_hold = 1'b0;
    run_start();
    chk("t5_restart", state, 2'd1);
    repeat (74) tick();
    chk("t5_pre_tmo", state, 2'd1);
    chk("t5_pre_cnt", cycle_cnt, 74);
    tick();
    chk("t5_tmo", state, 2'd3);
    chk("t5_tmo_cnt", cycle_cnt, 74);
    chk("t5_done", done, 1'b1);
    run_start();
    for (int t = 1; t <= 75; t++) begin
      tick();
      if (t == 66) pc_hold = 1'b1;
      if (t == 74) chk("t5_co_run", state, 2'd1);
    end
    chk("t5_co_halt", state, 2'd2);
    chk("t5_co_cnt", cycle_cnt, 74);

    // Asynchronous reset mid-run
    pc_hold = 1'b0;
    run_start();
    trc_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(5'd7, 32'h70 + i);
    chk("t6_queued", trc_valid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_valid", trc_valid, 1'b0);
    chk("t6_state", state, 2'd0);
    chk("t6_cycle", cycle_cnt, 0);
    chk("t6_data", trc_data, 0);
    sb_q.delete();
    tick();
    rst = 1'b1;
    tick();
    chk("t6_idle", state, 2'd0);
    trc_ready = 1'b1;
    run_start();
    wr(5'd7, 32'h99);
    chk("t6_ts0", trc_cycle, 0);
    chk("t6_dat", trc_data, 32'h99);
    tick();
    chk("t6_empty", trc_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
